// File: rtl/rs_alu_pkg.sv
// Shared constants, opcodes and entry payload types for the ALU reservation station.
package rs_alu_pkg;

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned ROB_WIDTH     = 4;
    localparam int unsigned OPERATION_BUS = 6;

    localparam logic [OPERATION_BUS-1:0] OP_NOP  = 6'd0;
    localparam logic [OPERATION_BUS-1:0] OP_ADD  = 6'd1;
    localparam logic [OPERATION_BUS-1:0] OP_SUB  = 6'd2;
    localparam logic [OPERATION_BUS-1:0] OP_AND  = 6'd3;
    localparam logic [OPERATION_BUS-1:0] OP_OR   = 6'd4;
    localparam logic [OPERATION_BUS-1:0] OP_XOR  = 6'd5;
    localparam logic [OPERATION_BUS-1:0] OP_SLL  = 6'd6;
    localparam logic [OPERATION_BUS-1:0] OP_SRL  = 6'd7;
    localparam logic [OPERATION_BUS-1:0] OP_SRA  = 6'd8;
    localparam logic [OPERATION_BUS-1:0] OP_SLT  = 6'd9;
    localparam logic [OPERATION_BUS-1:0] OP_SLTU = 6'd10;

    // One source operand: either a valid value or the ROB tag of its producer.
    typedef struct packed {
        logic                  rdy;
        logic [DATA_WIDTH-1:0] val;
        logic [ROB_WIDTH-1:0]  tag;
    } rs_opnd_t;

    // One reservation-station slot.
    typedef struct packed {
        logic                     busy;
        logic [OPERATION_BUS-1:0] op;
        logic [ROB_WIDTH-1:0]     rob_tag;
        logic [DATA_WIDTH-1:0]    pc;
        logic [DATA_WIDTH-1:0]    imm;
        rs_opnd_t                 a;
        rs_opnd_t                 b;
    } rs_entry_t;

    // Capture a CDB broadcast into an operand still waiting on that tag.
    function automatic rs_opnd_t wake_opnd(
        input rs_opnd_t              opnd,
        input logic                  cdb_valid,
        input logic [ROB_WIDTH-1:0]  cdb_tag,
        input logic [DATA_WIDTH-1:0] cdb_data
    );
        rs_opnd_t res;
        res = opnd;
        if (!opnd.rdy && cdb_valid && (opnd.tag == cdb_tag)) begin
            res.rdy = 1'b1;
            res.val = cdb_data;
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_priority_enc.sv
// Lowest-index-first priority encoder shared by free-slot and issue selection.
module rs_priority_enc #(
    parameter int unsigned RS_SIZE = 8,
    parameter int unsigned IDX_W   = 3
) (
    input  logic [RS_SIZE-1:0] req,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    // Scan high to low so the lowest set bit wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: dispatch, CDB wakeup/forwarding, single in-order-by-index issue.
module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int unsigned RS_SIZE = 8,
    parameter int unsigned IDX_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [OPERATION_BUS-1:0] in_op,
    input  logic [ROB_WIDTH-1:0]     in_rob_tag,
    input  logic [DATA_WIDTH-1:0]    in_pc,
    input  logic [DATA_WIDTH-1:0]    in_imm,
    input  logic [DATA_WIDTH-1:0]    in_a_val,
    input  logic [DATA_WIDTH-1:0]    in_b_val,
    input  logic [ROB_WIDTH-1:0]     in_a_tag,
    input  logic [ROB_WIDTH-1:0]     in_b_tag,
    input  logic                     in_a_rdy,
    input  logic                     in_b_rdy,
    input  logic                     cdb_valid,
    input  logic [ROB_WIDTH-1:0]     cdb_tag,
    input  logic [DATA_WIDTH-1:0]    cdb_data,
    output logic                     full,
    output logic [OPERATION_BUS-1:0] ex_op,
    output logic [ROB_WIDTH-1:0]     ex_rob_tag,
    output logic [DATA_WIDTH-1:0]    ex_pc,
    output logic [DATA_WIDTH-1:0]    ex_a,
    output logic [DATA_WIDTH-1:0]    ex_b,
    output logic [DATA_WIDTH-1:0]    ex_imm
);

    rs_entry_t          ent_q [RS_SIZE];
    rs_entry_t          ent_d [RS_SIZE];
    rs_entry_t          iss_ent;
    rs_opnd_t           disp_a;
    rs_opnd_t           disp_b;
    logic [RS_SIZE-1:0] busy_vec;
    logic [RS_SIZE-1:0] free_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   issue_idx;
    logic               free_found;
    logic               issue_found;
    logic               dispatch_en;

    // Occupancy and issue-eligibility vectors from registered state only.
    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy && ent_q[i].a.rdy && ent_q[i].b.rdy;
        end
    end

    assign free_vec    = ~busy_vec;
    assign full        = &busy_vec;
    assign dispatch_en = in_valid && free_found;
    assign iss_ent     = ent_q[issue_idx];

    rs_priority_enc #(.RS_SIZE(RS_SIZE), .IDX_W(IDX_W)) u_free_enc (
        .req   (free_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_priority_enc #(.RS_SIZE(RS_SIZE), .IDX_W(IDX_W)) u_issue_enc (
        .req   (ready_vec),
        .idx   (issue_idx),
        .found (issue_found)
    );

    // Incoming operands, forwarded from a same-cycle CDB broadcast when it matches.
    always_comb begin
        disp_a = wake_opnd('{rdy: in_a_rdy, val: in_a_val, tag: in_a_tag},
                           cdb_valid, cdb_tag, cdb_data);
        disp_b = wake_opnd('{rdy: in_b_rdy, val: in_b_val, tag: in_b_tag},
                           cdb_valid, cdb_tag, cdb_data);
    end

    // Per-entry next state: wakeup, release on issue, fill on dispatch.
    // Free slot comes from registered busy bits, so a slot freed by issue is
    // only reusable from the following cycle.
    always_comb begin
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].busy) begin
                ent_d[i].a = wake_opnd(ent_q[i].a, cdb_valid, cdb_tag, cdb_data);
                ent_d[i].b = wake_opnd(ent_q[i].b, cdb_valid, cdb_tag, cdb_data);
            end
            if (issue_found && (issue_idx == IDX_W'(i))) begin
                ent_d[i].busy = 1'b0;
            end
            if (dispatch_en && (free_idx == IDX_W'(i))) begin
                ent_d[i].busy    = 1'b1;
                ent_d[i].op      = in_op;
                ent_d[i].rob_tag = in_rob_tag;
                ent_d[i].pc      = in_pc;
                ent_d[i].imm     = in_imm;
                ent_d[i].a       = disp_a;
                ent_d[i].b       = disp_b;
            end
        end
    end

    // Entry storage; reset and flush both drop every entry.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (rst || flush) begin
                ent_q[i] <= '0;
            end else begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    // Execute-stage registers; op/tag fall to NOP when nothing issues, data holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_op      <= OP_NOP;
            ex_rob_tag <= '0;
            ex_pc      <= '0;
            ex_a       <= '0;
            ex_b       <= '0;
            ex_imm     <= '0;
        end else if (flush || !issue_found) begin
            ex_op      <= OP_NOP;
            ex_rob_tag <= '0;
        end else begin
            ex_op      <= iss_ent.op;
            ex_rob_tag <= iss_ent.rob_tag;
            ex_pc      <= iss_ent.pc;
            ex_a       <= iss_ent.a.val;
            ex_b       <= iss_ent.b.val;
            ex_imm     <= iss_ent.imm;
        end
    end

endmodule
